// File: rtl/tms_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tms_sequencer
// Purpose  : TMS1000-family program sequencer (PC/page/chapter, buffers, call
//            stack, ROM fetch). Optional macro TMS_SEQ_OVF_TRAP_EN turns a
//            call-stack overflow into a terminal ERROR state.
// Revision : 1.0 - initial release
// ============================================================================
module tms_sequencer #(
   parameter int PAGE_BITS    = 4,
   parameter int CHAPTER_BITS = 1,
   parameter int STACK_DEPTH  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               halt,
   output logic                               fetch_req,
   output logic [CHAPTER_BITS+PAGE_BITS+5:0]  rom_addr,
   input  logic                               instr_valid,
   input  logic [7:0]                         instruction,
   input  logic                               status,
   output logic [7:0]                         instr_out,
   output logic                               exec_strobe,
   output logic [3:0]                         stack_level,
   output logic                               error
);

   localparam int                      c_ENTRY_W = CHAPTER_BITS + PAGE_BITS + 6;
   localparam logic [3:0]              c_SP_MAX  = 4'(STACK_DEPTH);
   localparam logic [CHAPTER_BITS-1:0] c_CB_ONE  = CHAPTER_BITS'(1);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [5:0]              r_pc, w_pc_nxt;
   logic [PAGE_BITS-1:0]    r_page, w_page_nxt, r_pb, w_pb_nxt;
   logic [CHAPTER_BITS-1:0] r_chapter, w_chapter_nxt, r_cb, w_cb_nxt;
   logic [3:0]              r_sp, w_sp_nxt;
   logic [7:0]              r_instr, w_instr_nxt;
   logic                    r_error, w_error_nxt;
   logic                    w_push;
   logic [c_ENTRY_W-1:0]    w_push_data, w_top;
   logic [c_ENTRY_W-1:0]    r_stack [STACK_DEPTH];

   // Maximal-length shift-register PC sequence used by the TMS1000 family.
   function automatic logic [5:0] pc_step(input logic [5:0] pc);
      if (pc == 6'h1F)      return 6'h3F;
      else if (pc == 6'h3F) return 6'h3E;
      else                  return {pc[4:0], ~(pc[5] ^ pc[4])};
   endfunction

   always_comb begin
      w_top = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (r_sp == 4'(i + 1)) w_top = r_stack[i];
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_page_nxt    = r_page;
      w_pb_nxt      = r_pb;
      w_chapter_nxt = r_chapter;
      w_cb_nxt      = r_cb;
      w_sp_nxt      = r_sp;
      w_instr_nxt   = r_instr;
      w_error_nxt   = r_error;
      w_push        = 1'b0;
      w_push_data   = {r_chapter, r_page, r_pc};
      fetch_req     = 1'b0;
      exec_strobe   = 1'b0;

      case (r_state)
         ST_FETCH: begin
            fetch_req = !halt && !reset;
            if (!halt && instr_valid) begin
               w_instr_nxt = instruction;
               w_pc_nxt    = pc_step(r_pc);
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            exec_strobe = 1'b1;
            w_state_nxt = ST_FETCH;
            if (r_instr[7:4] == 4'b0001) begin
               w_pb_nxt = PAGE_BITS'(r_instr[3:0]);
            end else if (r_instr == 8'h0B) begin
               w_cb_nxt = r_cb ^ c_CB_ONE;
            end else if (r_instr == 8'h0F) begin
               if (r_sp != 4'd0) begin
                  w_pc_nxt      = w_top[5:0];
                  w_page_nxt    = w_top[PAGE_BITS+5:6];
                  w_pb_nxt      = w_top[PAGE_BITS+5:6];
                  w_chapter_nxt = w_top[c_ENTRY_W-1 -: CHAPTER_BITS];
                  w_sp_nxt      = r_sp - 4'd1;
               end else begin
                  w_page_nxt = r_pb;
               end
            end else if (r_instr[7] && status) begin
               if (r_instr[6] && (r_sp < c_SP_MAX)) begin
                  w_push        = 1'b1;
                  w_page_nxt    = r_pb;
                  w_pb_nxt      = r_page;
                  w_chapter_nxt = r_cb;
                  w_pc_nxt      = r_instr[5:0];
                  w_sp_nxt      = r_sp + 4'd1;
               end
`ifdef TMS_SEQ_OVF_TRAP_EN
               else if (r_instr[6]) begin
                  w_error_nxt = 1'b1;
                  w_pc_nxt    = r_pc;
                  w_state_nxt = ST_ERROR;
               end
`endif
               else begin
                  // Plain branch; an overflowing call also lands here.
                  w_pc_nxt      = r_instr[5:0];
                  w_chapter_nxt = r_cb;
                  if (r_sp == 4'd0) w_page_nxt = r_pb;
               end
            end
         end
         ST_ERROR: begin
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_FETCH;
         r_pc      <= '0;
         r_page    <= '0;
         r_pb      <= '0;
         r_chapter <= '0;
         r_cb      <= '0;
         r_sp      <= '0;
         r_instr   <= '0;
         r_error   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_page    <= w_page_nxt;
         r_pb      <= w_pb_nxt;
         r_chapter <= w_chapter_nxt;
         r_cb      <= w_cb_nxt;
         r_sp      <= w_sp_nxt;
         r_instr   <= w_instr_nxt;
         r_error   <= w_error_nxt;
      end
   end

   // Stack storage needs no reset; push is impossible while reset holds FETCH.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (w_push && (r_sp == 4'(i))) r_stack[i] <= w_push_data;
      end
   end

   assign rom_addr    = {r_chapter, r_page, r_pc};
   assign instr_out   = r_instr;
   assign stack_level = r_sp;
   assign error       = r_error;

endmodule
`default_nettype wire
